// File: rtl/ahb_write_slave.sv
// AHB-Lite slave write path for the 8-bit register block.
// Holds payload/size registers and inserts programmable wait states and two-cycle ERROR responses.
module ahb_write_slave #(
  parameter int WAIT_STATES = 1
) (
  input  logic       hclk,
  input  logic       hreset_n,
  input  logic       hsel_x,
  input  logic       hready,
  input  logic       hwrite,
  input  logic [1:0] htrans,
  input  logic [2:0] hsize,
  input  logic [1:0] haddr,
  input  logic [7:0] hwdata,
  output logic       hreadyout,
  output logic       hresp,
  output logic [7:0] payload_0,
  output logic [7:0] payload_1,
  output logic [4:0] data_size,
  output logic       wr_valid,
  output logic [1:0] wr_addr
);

  localparam int CW = (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ERR
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      addr_q, addr_d;
  logic            addr_err_q, addr_err_d;
  logic [7:0]      payload_0_q, payload_0_d;
  logic [7:0]      payload_1_q, payload_1_d;
  logic [4:0]      data_size_q, data_size_d;
  logic            wr_valid_q, wr_valid_d;
  logic [1:0]      wr_addr_q, wr_addr_d;

  logic accept;
  logic data_err;
  logic start_phase;
  logic unused_htrans;

  assign unused_htrans = htrans[0];
  assign accept   = hsel_x & hready & htrans[1] & hwrite;
  // data_size only holds 5 bits, so any upper hwdata bit makes that write illegal
  assign data_err = addr_err_q | ((addr_q == 2'd3) & (hwdata[7:5] != 3'b000));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    addr_err_d  = addr_err_q;
    payload_0_d = payload_0_q;
    payload_1_d = payload_1_q;
    data_size_d = data_size_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    hreadyout   = 1'b1;
    hresp       = 1'b0;
    start_phase = 1'b0;

    case (state_q)
      IDLE: begin
        start_phase = accept;
      end
      DATA: begin
        if (data_err) begin
          hreadyout = 1'b0;
          hresp     = 1'b1;
          state_d   = ERR;
        end else if (cnt_q != '0) begin
          hreadyout = 1'b0;
          cnt_d     = cnt_q - CW'(1'b1);
        end else begin
          case (addr_q)
            2'd1:    payload_0_d = hwdata;
            2'd2:    payload_1_d = hwdata;
            2'd3:    data_size_d = hwdata[4:0];
            default: ;
          endcase
          wr_valid_d  = 1'b1;
          wr_addr_d   = addr_q;
          state_d     = IDLE;
          start_phase = accept;
        end
      end
      ERR: begin
        hresp       = 1'b1;
        state_d     = IDLE;
        start_phase = accept;
      end
      default: state_d = IDLE;
    endcase

    // a newly accepted address phase overrides the return to IDLE
    if (start_phase) begin
      state_d    = DATA;
      cnt_d      = CNT_LOAD;
      addr_d     = haddr;
      addr_err_d = (haddr == 2'd0) | (hsize != 3'b000);
    end
  end

  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      addr_err_q  <= 1'b0;
      payload_0_q <= '0;
      payload_1_q <= '0;
      data_size_q <= '0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      addr_err_q  <= addr_err_d;
      payload_0_q <= payload_0_d;
      payload_1_q <= payload_1_d;
      data_size_q <= data_size_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
    end
  end

  assign payload_0 = payload_0_q;
  assign payload_1 = payload_1_q;
  assign data_size = data_size_q;
  assign wr_valid  = wr_valid_q;
  assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_ahb_write_slave.sv
// Bench for ahb_write_slave: one instance with no wait states, one with two,
// each checked every cycle against a transaction-level model plus literal expectations.
module tb_ahb_write_slave;

  localparam int W0 = 0;
  localparam int W1 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       hsel [2];
  logic       hwr  [2];
  logic [1:0] htr  [2];
  logic [2:0] hsz  [2];
  logic [1:0] had  [2];
  logic [7:0] hwd  [2];
  logic       rdy  [2];
  logic       resp [2];
  logic       wv   [2];
  logic [7:0] p0   [2];
  logic [7:0] p1   [2];
  logic [4:0] ds   [2];
  logic [1:0] wa   [2];

  int n_cmp = 0;
  int n_bad = 0;
  logic [15:0] rdy_hist;
  logic [15:0] resp_hist;

  // Each slave is alone on its bus, so its own hreadyout is the bus hready.
  ahb_write_slave #(.WAIT_STATES(W0)) u_dut0 (
    .hclk(clk), .hreset_n(rst_n), .hsel_x(hsel[0]), .hready(rdy[0]), .hwrite(hwr[0]),
    .htrans(htr[0]), .hsize(hsz[0]), .haddr(had[0]), .hwdata(hwd[0]),
    .hreadyout(rdy[0]), .hresp(resp[0]), .payload_0(p0[0]), .payload_1(p1[0]),
    .data_size(ds[0]), .wr_valid(wv[0]), .wr_addr(wa[0])
  );

  ahb_write_slave #(.WAIT_STATES(W1)) u_dut1 (
    .hclk(clk), .hreset_n(rst_n), .hsel_x(hsel[1]), .hready(rdy[1]), .hwrite(hwr[1]),
    .htrans(htr[1]), .hsize(hsz[1]), .haddr(had[1]), .hwdata(hwd[1]),
    .hreadyout(rdy[1]), .hresp(resp[1]), .payload_0(p0[1]), .payload_1(p1[1]),
    .data_size(ds[1]), .wr_valid(wv[1]), .wr_addr(wa[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction model: a pending write with its age in data-phase cycles, an error tail flag,
  // and a plain register array indexed by address.
  logic       m_pend [2];
  logic       m_aerr [2];
  logic       m_tail [2];
  logic       m_wv   [2];
  logic [1:0] m_addr [2];
  logic [1:0] m_wa   [2];
  int         m_age  [2];
  logic [7:0] m_reg  [2][4];

  function automatic int wait_of(input int u);
    return (u == 0) ? W0 : W1;
  endfunction

  function automatic logic m_err(input int u);
    return m_pend[u] && (m_aerr[u] || (m_addr[u] == 2'd3 && hwd[u][7:5] != 3'b000));
  endfunction

  function automatic logic m_rdy(input int u);
    if (m_pend[u]) return !m_err(u) && (m_age[u] >= wait_of(u));
    return 1'b1;
  endfunction

  function automatic logic m_resp(input int u);
    return m_err(u) || (!m_pend[u] && m_tail[u]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int u = 0; u < 2; u++) begin
        m_pend[u] <= 1'b0;
        m_aerr[u] <= 1'b0;
        m_tail[u] <= 1'b0;
        m_wv[u]   <= 1'b0;
        m_addr[u] <= 2'd0;
        m_wa[u]   <= 2'd0;
        m_age[u]  <= 0;
        for (int r = 0; r < 4; r++) m_reg[u][r] <= 8'h00;
      end
    end else begin
      for (int u = 0; u < 2; u++) begin
        m_wv[u]   <= 1'b0;
        m_tail[u] <= 1'b0;
        if (m_pend[u]) begin
          if (m_err(u)) begin
            m_pend[u] <= 1'b0;
            m_tail[u] <= 1'b1;
          end else if (m_age[u] < wait_of(u)) begin
            m_age[u] <= m_age[u] + 1;
          end else begin
            m_reg[u][m_addr[u]] <= (m_addr[u] == 2'd3) ? (hwd[u] & 8'h1F) : hwd[u];
            m_wv[u]   <= 1'b1;
            m_wa[u]   <= m_addr[u];
            m_pend[u] <= 1'b0;
          end
        end
        if (hsel[u] && m_rdy(u) && htr[u][1] && hwr[u]) begin
          m_pend[u] <= 1'b1;
          m_age[u]  <= 0;
          m_addr[u] <= had[u];
          m_aerr[u] <= (had[u] == 2'd0) || (hsz[u] != 3'b000);
          m_tail[u] <= 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison of both slaves against the model.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      check($sformatf("u%0d_hreadyout", u), rdy[u],  m_rdy(u));
      check($sformatf("u%0d_hresp", u),     resp[u], m_resp(u));
      check($sformatf("u%0d_payload_0", u), p0[u],   m_reg[u][1]);
      check($sformatf("u%0d_payload_1", u), p1[u],   m_reg[u][2]);
      check($sformatf("u%0d_data_size", u), ds[u],   m_reg[u][3][4:0]);
      check($sformatf("u%0d_wr_valid", u),  wv[u],   m_wv[u]);
      check($sformatf("u%0d_wr_addr", u),   wa[u],   m_wa[u]);
    end
  end

  task automatic set_idle(input int u);
    hsel[u] = 1'b0;
    hwr[u]  = 1'b0;
    htr[u]  = 2'd0;
    had[u]  = 2'd0;
    hsz[u]  = 3'd0;
  endtask

  task automatic drive_addr(input int u, input int idx, input logic [1:0] a, input logic [2:0] size);
    hsel[u] = 1'b1;
    hwr[u]  = 1'b1;
    htr[u]  = (idx == 0) ? 2'd2 : 2'd3;
    had[u]  = a;
    hsz[u]  = size;
  endtask

  // Pipelined write burst of n transfers; logs hreadyout/hresp of every data-phase cycle.
  task automatic run_burst(input int u, input int n, input logic [7:0] addrs,
                           input logic [31:0] datas, input logic [2:0] size);
    int ap;
    int dp;
    int cyc;
    logic r;
    ap = 0;
    dp = -1;
    cyc = 0;
    rdy_hist = '0;
    resp_hist = '0;
    @(posedge clk); #1;
    drive_addr(u, 0, addrs[1:0], size);
    while ((ap < n || dp >= 0) && cyc < 60) begin
      @(negedge clk);
      r = rdy[u];
      if (dp >= 0) begin
        rdy_hist  = {rdy_hist[14:0], r};
        resp_hist = {resp_hist[14:0], resp[u]};
      end
      @(posedge clk); #1;
      cyc++;
      if (r) begin
        dp = (ap < n) ? ap : -1;
        if (ap < n) ap++;
        if (ap < n) drive_addr(u, ap, addrs[ap*2 +: 2], size);
        else set_idle(u);
        if (dp >= 0) hwd[u] = datas[dp*8 +: 8];
      end
    end
    if (cyc >= 60) check("burst_timeout", 1, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int u = 0; u < 2; u++) begin
      set_idle(u);
      hwd[u] = 8'h00;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check("rst_hreadyout", rdy[u], 1);
      check("rst_hresp", resp[u], 0);
      check("rst_payload_0", p0[u], 0);
      check("rst_wr_valid", wv[u], 0);
    end

    $display("[TB] zero-wait write to payload_0");
    run_burst(0, 1, 8'h01, 32'h0000_00A5, 3'd0);
    check("t2_dphase_ready", rdy_hist[0], 1);
    @(negedge clk);
    check("t2_payload_0", p0[0], 8'hA5);
    check("t2_wr_valid", wv[0], 1);
    check("t2_wr_addr", wa[0], 1);
    @(negedge clk);
    check("t2_wr_valid_drop", wv[0], 0);

    $display("[TB] two-wait write to payload_1");
    run_burst(1, 1, 8'h02, 32'h0000_003C, 3'd0);
    check("t3_ready_seq", rdy_hist[2:0], 3'b001);
    check("t3_resp_seq", resp_hist[2:0], 3'b000);
    @(negedge clk);
    check("t3_payload_1", p1[1], 8'h3C);

    $display("[TB] illegal writes");
    run_burst(0, 1, 8'h00, 32'h0000_00FF, 3'd0);
    check("t4_addr0_ready_seq", rdy_hist[1:0], 2'b01);
    check("t4_addr0_resp_seq", resp_hist[1:0], 2'b11);
    @(negedge clk);
    check("t4_addr0_payload_0", p0[0], 8'hA5);
    check("t4_addr0_wr_valid", wv[0], 0);
    run_burst(1, 1, 8'h01, 32'h0000_0055, 3'd1);
    check("t4_size_ready_seq", rdy_hist[1:0], 2'b01);
    check("t4_size_resp_seq", resp_hist[1:0], 2'b11);
    @(negedge clk);
    check("t4_size_payload_0", p0[1], 8'h00);
    check("t4_size_wr_valid", wv[1], 0);

    $display("[TB] data_size range");
    run_burst(0, 1, 8'h03, 32'h0000_0025, 3'd0);
    check("t5_bad_resp_seq", resp_hist[1:0], 2'b11);
    @(negedge clk);
    check("t5_bad_data_size", ds[0], 5'h00);
    run_burst(0, 1, 8'h03, 32'h0000_0013, 3'd0);
    check("t5_ok_resp", resp_hist[0], 0);
    @(negedge clk);
    check("t5_ok_data_size", ds[0], 5'h13);

    $display("[TB] back-to-back bursts");
    run_burst(0, 2, 8'b0000_1001, 32'h0000_2211, 3'd0);
    check("t6_ready_seq", rdy_hist[1:0], 2'b11);
    @(negedge clk);
    check("t6_payload_0", p0[0], 8'h11);
    check("t6_payload_1", p1[0], 8'h22);
    check("t6_wr_valid", wv[0], 1);
    check("t6_wr_addr", wa[0], 2);
    run_burst(1, 2, 8'b0000_0111, 32'h0000_9905, 3'd0);
    check("t6w_ready_seq", rdy_hist[5:0], 6'b001001);
    @(negedge clk);
    check("t6w_data_size", ds[1], 5'h05);
    check("t6w_payload_0", p0[1], 8'h99);

    $display("[TB] reset during wait state");
    @(posedge clk); #1;
    drive_addr(1, 0, 2'd1, 3'd0);
    @(posedge clk); #1;
    set_idle(1);
    hwd[1] = 8'h77;
    @(negedge clk);
    check("rw_waiting", rdy[1], 0);
    #2 rst_n = 1'b0;
    #1;
    check("rw_hreadyout", rdy[1], 1);
    check("rw_hresp", resp[1], 0);
    check("rw_u1_payload_0", p0[1], 0);
    check("rw_u1_data_size", ds[1], 0);
    check("rw_u0_payload_0", p0[0], 0);
    check("rw_u0_payload_1", p1[0], 0);
    check("rw_u0_data_size", ds[0], 0);
    check("rw_u0_wr_addr", wa[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("rw_no_write", p0[1], 0);
    check("rw_no_wr_valid", wv[1], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
